pp_row_accum_mult: RTL and testbench

//  Iterative multiplier that generates ROWS_PER_CYCLE partial-product rows per clock and accumulates them.

---
 rtl/pp_mult_pkg.sv | 23 ++
 rtl/pp_row_gen.sv | 12 +
 rtl/pp_row_accum_mult.sv | 125 ++++++++++++
 tb/tb_pp_row_accum_mult.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pp_mult_pkg.sv
// Shared definitions for the partial-product multipliers: FSM state encodings
// and a constant clog2 used to size counters and row indices.
package pp_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pp_row_gen.sv
// One partial-product row: the multiplicand y gated by a single multiplier bit x.
module pp_row_gen #(
  parameter int WIDTH = 8
) (
  input  logic             x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z
);

  assign z = {WIDTH{x}} & y;

endmodule

// File: rtl/pp_row_accum_mult.sv
// Iterative multiplier: accumulates ROWS_PER_CYCLE shifted partial-product rows
// per clock into a 2*WIDTH accumulator; unsigned or two's complement per operation.
module pp_row_accum_mult
  import pp_mult_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);

  localparam int PW   = 2 * WIDTH;
  localparam int NGRP = WIDTH / ROWS_PER_CYCLE;
  localparam int CW   = (clog2(NGRP) < 1) ? 1 : clog2(NGRP);
  localparam int KW   = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

  if (WIDTH % ROWS_PER_CYCLE != 0) begin : g_bad_rows
    $error("ROWS_PER_CYCLE must divide WIDTH");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic            sgn_q, sgn_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   p_q, p_d;

  logic [PW-1:0]   row_val [ROWS_PER_CYCLE];
  logic            row_neg [ROWS_PER_CYCLE];
  logic [PW-1:0]   sum;

  // a_q already holds the operand extended to 2W, so each row is a plain shift.
  for (genvar gi = 0; gi < ROWS_PER_CYCLE; gi++) begin : g_rows
    logic [KW-1:0] row_idx;
    logic [PW-1:0] row_shift;

    assign row_idx     = KW'(32'(cnt_q) * ROWS_PER_CYCLE + gi);
    assign row_shift   = a_q << row_idx;
    assign row_neg[gi] = sgn_q && (row_idx == KW'(WIDTH - 1));

    pp_row_gen #(.WIDTH(PW)) u_row_gen (
      .x (b_q[row_idx]),
      .y (row_shift),
      .z (row_val[gi])
    );
  end

  // The multiplier MSB carries weight -2^(W-1) in signed mode, so that row is subtracted.
  always_comb begin
    sum = acc_q;
    for (int i = 0; i < ROWS_PER_CYCLE; i++) begin
      if (row_neg[i]) sum = sum - row_val[i];
      else            sum = sum + row_val[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    acc_d   = acc_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          cnt_d   = '0;
          acc_d   = '0;
          a_d     = in_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};
          b_d     = in_b;
          sgn_d   = in_signed;
        end
      end
      RUN: begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NGRP - 1)) begin
          state_d = DONE;
          p_d     = sum;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_p     = p_q;

endmodule

// File: tb/tb_pp_row_accum_mult.sv
// Self-checking bench: four multiplier configurations, directed corner cases plus
// randomized traffic, each output compared every cycle against a transaction-level model.
module tb_pp_row_accum_mult;

  localparam int NCFG    = 4;
  localparam int NRAND   = 2000;
  localparam int TIMEOUT = 200;

  function automatic int cfg_w(input int i);
    return (i == 3) ? 16 : 8;
  endfunction

  function automatic int cfg_r(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  // Reference product: interpret operands as integers and multiply, modulo 2^(2w).
  function automatic logic [31:0] mul_ref(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic s);
    longint av, bv, pr, mask_in;
    mask_in = (longint'(1) << w) - 1;
    av = longint'(a) & mask_in;
    bv = longint'(b) & mask_in;
    if (s && a[w-1]) av = av - (longint'(1) << w);
    if (s && b[w-1]) bv = bv - (longint'(1) << w);
    pr = av * bv;
    return 32'(pr & ((longint'(1) << (2 * w)) - 1));
  endfunction

  function automatic logic [15:0] pick(input int w);
    int          m;
    logic [15:0] mask;
    m    = int'($urandom_range(0, 7));
    mask = 16'((32'd1 << w) - 1);
    case (m)
      0:       return 16'd0;
      1:       return 16'(32'd1 << (w - 1));
      2:       return mask;
      default: return 16'($urandom) & mask;
    endcase
  endfunction

  logic        clk;
  logic        rst_n     [NCFG];
  logic        in_valid  [NCFG];
  logic        in_ready  [NCFG];
  logic        in_signed [NCFG];
  logic        out_valid [NCFG];
  logic        out_ready [NCFG];
  logic [15:0] a_s       [NCFG];
  logic [15:0] b_s       [NCFG];
  logic [31:0] p_s       [NCFG];

  int vectors     = 0;
  int miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
    localparam int W = cfg_w(gi);
    localparam int R = cfg_r(gi);
    localparam int L = W / R;

    logic [2*W-1:0] p;

    pp_row_accum_mult #(.WIDTH(W), .ROWS_PER_CYCLE(R)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[gi]),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready[gi]),
      .in_signed (in_signed[gi]),
      .in_a      (a_s[gi][W-1:0]),
      .in_b      (b_s[gi][W-1:0]),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready[gi]),
      .out_p     (p)
    );

    assign p_s[gi] = 32'(p);

    // Transaction model: busy from accept until the output handshake; the result
    // becomes visible L edges after accept and out_p holds it until the next result.
    bit          m_init  = 1'b0;
    bit          m_busy  = 1'b0;
    int          m_edges = 0;
    logic [31:0] m_exp   = '0;
    logic [31:0] m_shown = '0;

    always @(negedge clk) begin
      bit bad;
      if (m_init) begin
        bad = 1'b0;
        vectors++;
        if (in_ready[gi] !== !m_busy) begin
          $display("FAIL mon_in_ready[%0d] t=%0t: got %b required %b", gi, $time, in_ready[gi], !m_busy);
          bad = 1'b1;
        end
        if (out_valid[gi] !== (m_busy && m_edges == L)) begin
          $display("FAIL mon_out_valid[%0d] t=%0t: got %b required %b", gi, $time, out_valid[gi],
                   (m_busy && m_edges == L));
          bad = 1'b1;
        end
        if (p_s[gi] !== m_shown) begin
          $display("FAIL mon_out_p[%0d] t=%0t: got %0h required %0h", gi, $time, p_s[gi], m_shown);
          bad = 1'b1;
        end
        if (bad) miscompares++;
      end
      if (!rst_n[gi]) begin
        m_init  = 1'b1;
        m_busy  = 1'b0;
        m_shown = '0;
      end else if (m_init) begin
        if (!m_busy) begin
          if (in_valid[gi]) begin
            m_busy  = 1'b1;
            m_edges = 0;
            m_exp   = mul_ref(W, a_s[gi], b_s[gi], in_signed[gi]);
          end
        end else if (m_edges < L) begin
          m_edges++;
          if (m_edges == L) m_shown = m_exp;
        end else if (out_ready[gi]) begin
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic accept(input int id, input logic [15:0] a, input logic [15:0] b, input logic s);
    int guard;
    in_valid[id]  = 1'b1;
    a_s[id]       = a;
    b_s[id]       = b;
    in_signed[id] = s;
    guard = 0;
    while (in_ready[id] !== 1'b1 && guard < TIMEOUT) begin
      tick();
      guard++;
    end
    if (in_ready[id] !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout_in_ready[%0d]: in_ready 0 after %0d cycles, required 1", id, guard);
    end
    tick();
    in_valid[id]  = 1'b0;
    a_s[id]       = 16'($urandom);
    b_s[id]       = 16'($urandom);
    in_signed[id] = 1'($urandom);
  endtask

  task automatic collect(input int id, input int stall, input int start,
                         output logic [31:0] p, output int lat);
    lat = start;
    while (out_valid[id] !== 1'b1 && lat < TIMEOUT) begin
      tick();
      lat++;
    end
    if (out_valid[id] !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout_out_valid[%0d]: out_valid 0 after %0d edges, required 1", id, lat);
    end
    p = p_s[id];
    repeat (stall) tick();
    out_ready[id] = 1'b1;
    tick();
    out_ready[id] = 1'b0;
  endtask

  task automatic directed(input int id, input string name, input logic [15:0] a,
                          input logic [15:0] b, input logic s,
                          input logic [31:0] req_p, input int req_lat);
    logic [31:0] p;
    int          lat;
    accept(id, a, b, s);
    collect(id, 0, 0, p, lat);
    $display("[u%0d] %s a=%0h b=%0h s=%0b p=%0h lat=%0d", id, name, a, b, s, p, lat);
    check({name, "_p"}, p, req_p);
    check({name, "_lat"}, 32'(lat), 32'(req_lat));
  endtask

  task automatic run_random(input int id, input int n);
    int          w, l, lat;
    logic [15:0] a, b;
    logic        s;
    logic [31:0] p;
    w = cfg_w(id);
    l = cfg_w(id) / cfg_r(id);
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 2)) tick();
      a = pick(w);
      b = pick(w);
      s = 1'($urandom_range(0, 1));
      accept(id, a, b, s);
      collect(id, int'($urandom_range(0, 2)), 0, p, lat);
      $display("[u%0d] rand a=%0h b=%0h s=%0b p=%0h lat=%0d", id, a, b, s, p, lat);
      check($sformatf("rand_p[%0d]", id), p, mul_ref(w, a, b, s));
      check($sformatf("rand_lat[%0d]", id), 32'(lat), 32'(l));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] p;
    int          lat;

    for (int i = 0; i < NCFG; i++) begin
      rst_n[i]     = 1'b0;
      in_valid[i]  = 1'b0;
      in_signed[i] = 1'b0;
      out_ready[i] = 1'b0;
      a_s[i]       = '0;
      b_s[i]       = '0;
    end
    tick();
    tick();
    for (int i = 0; i < NCFG; i++) rst_n[i] = 1'b1;

    check("reset_in_ready", 32'(in_ready[0]), 32'd1);
    check("reset_out_valid", 32'(out_valid[0]), 32'd0);
    check("reset_out_p", p_s[0], 32'd0);

    directed(0, "u255x255", 16'hFF, 16'hFF, 1'b0, 32'hFE01, 8);
    directed(0, "s_m128xm128", 16'h80, 16'h80, 1'b1, 32'h4000, 8);
    directed(0, "s_m1x127", 16'hFF, 16'h7F, 1'b1, 32'hFF81, 8);
    directed(0, "s_127xm128", 16'h7F, 16'h80, 1'b1, 32'hC080, 8);
    directed(0, "u0xb", 16'h00, 16'hB7, 1'b0, 32'h0000, 8);
    directed(0, "s_ax0", 16'h93, 16'h00, 1'b1, 32'h0000, 8);
    directed(0, "s_0xm128", 16'h00, 16'h80, 1'b1, 32'h0000, 8);
    directed(1, "u200x3", 16'd200, 16'd3, 1'b0, 32'd600, 4);
    directed(1, "s_127xm128", 16'h7F, 16'h80, 1'b1, 32'hC080, 4);

    // Output held in DONE for 5 cycles while a new operand pair waits.
    accept(0, 16'd9, 16'd11, 1'b0);
    repeat (8) tick();
    check("stall_enter_valid", 32'(out_valid[0]), 32'd1);
    in_valid[0]  = 1'b1;
    a_s[0]       = 16'd3;
    b_s[0]       = 16'd3;
    in_signed[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_out_valid", 32'(out_valid[0]), 32'd1);
      check("stall_out_p", p_s[0], 32'd99);
      check("stall_in_ready", 32'(in_ready[0]), 32'd0);
    end
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    check("stall_release_in_ready", 32'(in_ready[0]), 32'd1);
    check("stall_release_out_valid", 32'(out_valid[0]), 32'd0);
    directed(0, "after_stall_3x3", 16'd3, 16'd3, 1'b0, 32'd9, 8);

    // A second operand pair offered mid-RUN must be ignored.
    accept(0, 16'd6, 16'd7, 1'b0);
    tick();
    tick();
    in_valid[0] = 1'b1;
    a_s[0]      = 16'd5;
    b_s[0]      = 16'd5;
    tick();
    in_valid[0] = 1'b0;
    collect(0, 0, 3, p, lat);
    $display("[u0] run_pulse a=6 b=7 p=%0h lat=%0d", p, lat);
    check("run_pulse_p", p, 32'd42);
    check("run_pulse_lat", 32'(lat), 32'd8);
    repeat (12) tick();
    check("run_pulse_no_extra", 32'(out_valid[0]), 32'd0);

    // Reset for one edge at RUN cnt=3 abandons the operation and clears out_p.
    accept(0, 16'd13, 16'd5, 1'b0);
    repeat (3) tick();
    rst_n[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;
    $display("[u0] reset_mid_run in_ready=%b out_valid=%b out_p=%0h", in_ready[0], out_valid[0], p_s[0]);
    check("rst_in_ready", 32'(in_ready[0]), 32'd1);
    check("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("rst_out_p", p_s[0], 32'd0);
    repeat (12) tick();
    check("rst_no_stale", 32'(out_valid[0]), 32'd0);

    fork
      run_random(0, NRAND);
      run_random(1, NRAND);
      run_random(2, NRAND);
      run_random(3, NRAND);
    join

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
